elevator_scan_controller: RTL

//  Parametrised N-floor elevator car controller: latches floor requests into a pending bitmap,

---
 rtl/elevator_scan_controller_if.sv | 50 +++++
 rtl/elevator_scan_controller.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller_if.sv
// Request/interlock inputs and car status outputs exchanged between the
// call-button logic (master) and the elevator car controller (slave).
interface elevator_scan_controller_if #(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = 3
);
    logic                  req_valid;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  door_hold;
    logic                  overweight;

    logic [FLOOR_W-1:0]    current_floor;
    logic                  direction;
    logic                  moving;
    logic                  door_open;
    logic                  arrived;
    logic [NUM_FLOORS-1:0] pending;
    logic                  weight_alert;
    logic                  door_alert;

    modport master (
        output req_valid,
        output req_floor,
        output door_hold,
        output overweight,
        input  current_floor,
        input  direction,
        input  moving,
        input  door_open,
        input  arrived,
        input  pending,
        input  weight_alert,
        input  door_alert
    );

    modport slave (
        input  req_valid,
        input  req_floor,
        input  door_hold,
        input  overweight,
        output current_floor,
        output direction,
        output moving,
        output door_open,
        output arrived,
        output pending,
        output weight_alert,
        output door_alert
    );
endinterface

// File: rtl/elevator_scan_controller.sv
// SCAN-order elevator car controller: pending-request bitmap, per-floor travel
// timing and a timed door with hold/overweight interlocks and an open-time alert.
module elevator_scan_controller #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8,
    parameter int DOOR_TIMEOUT  = 32,
    parameter int RESET_FLOOR   = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    elevator_scan_controller_if.slave bus
);

    localparam int TRAVEL_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W   = $clog2(DOOR_CYCLES + 1);
    localparam int OPEN_W   = $clog2(DOOR_TIMEOUT + 1);

    localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
    localparam logic [OPEN_W-1:0]   OPEN_MAX    = OPEN_W'(DOOR_TIMEOUT);
    localparam logic [FLOOR_W-1:0]  HOME_FLOOR  = FLOOR_W'(RESET_FLOOR);

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    state_e                state_q,         state_d;
    logic [FLOOR_W-1:0]    current_floor_q, current_floor_d;
    logic                  direction_q,     direction_d;
    logic [TRAVEL_W-1:0]   travel_cnt_q,    travel_cnt_d;
    logic [DOOR_W-1:0]     door_cnt_q,      door_cnt_d;
    logic [OPEN_W-1:0]     open_cnt_q,      open_cnt_d;
    logic [NUM_FLOORS-1:0] pending_q,       pending_d;
    logic                  arrived_q,       arrived_d;
    logic                  moving_q,        moving_d;
    logic                  door_open_q,     door_open_d;
    logic                  weight_alert_q,  weight_alert_d;
    logic                  door_alert_q,    door_alert_d;

    logic [NUM_FLOORS-1:0] req_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] cur_mask;
    logic [NUM_FLOORS-1:0] next_mask;
    logic [FLOOR_W-1:0]    next_floor;
    logic                  same_floor_req;

    // Out-of-range floor indices decode to an all-zero mask, so they are dropped.
    function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] floor);
        floor_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            floor_mask[i] = (floor == FLOOR_W'(i));
        end
    endfunction

    function automatic logic requests_ahead(
        input logic [NUM_FLOORS-1:0] bits,
        input logic [FLOOR_W-1:0]    floor,
        input logic                  up
    );
        requests_ahead = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (bits[i] && (up ? (FLOOR_W'(i) > floor) : (FLOOR_W'(i) < floor))) begin
                requests_ahead = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d         = state_q;
        current_floor_d = current_floor_q;
        direction_d     = direction_q;
        travel_cnt_d    = travel_cnt_q;
        door_cnt_d      = door_cnt_q;
        open_cnt_d      = open_cnt_q;
        arrived_d       = 1'b0;
        clear_mask      = '0;
        same_floor_req  = 1'b0;
        req_mask        = bus.req_valid ? floor_mask(bus.req_floor) : '0;
        cur_mask        = floor_mask(current_floor_q);
        next_floor      = direction_q ? (current_floor_q + FLOOR_W'(1))
                                      : (current_floor_q - FLOOR_W'(1));
        next_mask       = floor_mask(next_floor);

        case (state_q)
            IDLE: begin
                travel_cnt_d = '0;
                door_cnt_d   = '0;
                open_cnt_d   = '0;
                if (|(pending_q & cur_mask)) begin
                    state_d    = DOOR;
                    clear_mask = cur_mask;
                    arrived_d  = 1'b1;
                end else if (requests_ahead(pending_q, current_floor_q, direction_q)) begin
                    state_d = MOVE;
                end else if (requests_ahead(pending_q, current_floor_q, ~direction_q)) begin
                    state_d     = MOVE;
                    direction_d = ~direction_q;
                end
            end

            MOVE: begin
                if (travel_cnt_q == TRAVEL_LAST) begin
                    travel_cnt_d    = '0;
                    current_floor_d = next_floor;
                    if (|(pending_q & next_mask)) begin
                        state_d    = DOOR;
                        clear_mask = next_mask;
                        arrived_d  = 1'b1;
                        door_cnt_d = '0;
                        open_cnt_d = '0;
                    end else if (!requests_ahead(pending_q, next_floor, direction_q)) begin
                        // Defensive stop so the car can never run past the end floors.
                        state_d = IDLE;
                    end
                end else begin
                    travel_cnt_d = travel_cnt_q + TRAVEL_W'(1);
                end
            end

            DOOR: begin
                // A call for the floor we are standing at just keeps the door open.
                same_floor_req = |(req_mask & cur_mask);
                req_mask       = req_mask & ~cur_mask;
                if (open_cnt_q != OPEN_MAX) begin
                    open_cnt_d = open_cnt_q + OPEN_W'(1);
                end
                if (bus.door_hold || bus.overweight || same_floor_req) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DOOR_LAST) begin
                    state_d    = IDLE;
                    door_cnt_d = '0;
                    open_cnt_d = '0;
                end else begin
                    door_cnt_d = door_cnt_q + DOOR_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        pending_d      = (pending_q | req_mask) & ~clear_mask;
        moving_d       = (state_d == MOVE);
        door_open_d    = (state_d == DOOR);
        weight_alert_d = (state_d == DOOR) && bus.overweight;
        door_alert_d   = (state_d == DOOR) && (open_cnt_d == OPEN_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            current_floor_q <= HOME_FLOOR;
            direction_q     <= 1'b1;
            travel_cnt_q    <= '0;
            door_cnt_q      <= '0;
            open_cnt_q      <= '0;
            pending_q       <= '0;
            arrived_q       <= 1'b0;
            moving_q        <= 1'b0;
            door_open_q     <= 1'b0;
            weight_alert_q  <= 1'b0;
            door_alert_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            current_floor_q <= current_floor_d;
            direction_q     <= direction_d;
            travel_cnt_q    <= travel_cnt_d;
            door_cnt_q      <= door_cnt_d;
            open_cnt_q      <= open_cnt_d;
            pending_q       <= pending_d;
            arrived_q       <= arrived_d;
            moving_q        <= moving_d;
            door_open_q     <= door_open_d;
            weight_alert_q  <= weight_alert_d;
            door_alert_q    <= door_alert_d;
        end
    end

    assign bus.current_floor = current_floor_q;
    assign bus.direction     = direction_q;
    assign bus.moving        = moving_q;
    assign bus.door_open     = door_open_q;
    assign bus.arrived       = arrived_q;
    assign bus.pending       = pending_q;
    assign bus.weight_alert  = weight_alert_q;
    assign bus.door_alert    = door_alert_q;

endmodule
